// File: rtl/vslc_sevenseg_pkg.sv
// Shared types and hex font for the VSLC dual seven-segment display stage.
package vslc_sevenseg_pkg;

   typedef enum logic [1:0] {
      SHOW_LO  = 2'd0,
      BLANK_LO = 2'd1,
      SHOW_HI  = 2'd2,
      BLANK_HI = 2'd3
   } disp_state_t;

   // gfedcba, active-high; entry [n] is the glyph for nibble n
   localparam logic [15:0][6:0] HEX_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39,
      7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66,
      7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic is_show(input disp_state_t s);
      return (s == SHOW_LO) || (s == SHOW_HI);
   endfunction

endpackage

// File: rtl/vslc_hex_to_seg.sv
// Nibble to gfedcba glyph decoder, active-high, no polarity handling.
module vslc_hex_to_seg
   import vslc_sevenseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = HEX_FONT[nibble];

endmodule

// File: rtl/vslc_sevenseg_mux.sv
// Two-digit multiplexed seven-segment driver with frame-aligned
// double buffering and optional leading-zero suppression.
module vslc_sevenseg_mux
   import vslc_sevenseg_pkg::*;
#(
   parameter int CLK_DIV        = 6000,
   parameter int BLANK_CYCLES   = 64,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int EN_ACTIVE_LOW  = 0
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic [7:0] value,
   input  logic [1:0] dp_in,
   input  logic       load,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] en,
   output logic       frame
);

   localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] SHOW_TC  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_CYCLES - 1);

   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic EN_INV  = (EN_ACTIVE_LOW != 0);

   localparam logic [6:0] SEG_DARK = {7{SEG_INV}};
   localparam logic       DP_DARK  = SEG_INV;
   localparam logic [1:0] EN_DARK  = {2{EN_INV}};

   disp_state_t   state;
   disp_state_t   nxt_state;
   logic [CW-1:0] cnt;
   logic          last;
   logic          boundary;

   logic [7:0] pend_val;
   logic [1:0] pend_dp;
   logic [7:0] disp_val;
   logic [1:0] disp_dp;
   logic [7:0] nxt_val;
   logic [1:0] nxt_dp;

   logic [6:0] glyph_lo;
   logic [6:0] glyph_hi;
   logic [6:0] seg_raw;
   logic       dp_raw;
   logic [1:0] en_raw;

   assign last     = is_show(state) ? (cnt == SHOW_TC) : (cnt == BLANK_TC);
   assign boundary = (state == BLANK_HI) && last;

   // outputs are computed from the post-edge display so the new value
   // appears on the very edge it is latched
   assign nxt_val = boundary ? pend_val : disp_val;
   assign nxt_dp  = boundary ? pend_dp  : disp_dp;

   always_comb begin
      nxt_state = state;
      if (last) begin
         unique case (state)
            SHOW_LO:  nxt_state = BLANK_LO;
            BLANK_LO: nxt_state = SHOW_HI;
            SHOW_HI:  nxt_state = BLANK_HI;
            BLANK_HI: nxt_state = SHOW_LO;
            default:  nxt_state = BLANK_HI;
         endcase
      end
   end

   vslc_hex_to_seg u_dec_lo (
      .nibble (nxt_val[3:0]),
      .glyph  (glyph_lo)
   );

   vslc_hex_to_seg u_dec_hi (
      .nibble (nxt_val[7:4]),
      .glyph  (glyph_hi)
   );

   always_comb begin
      seg_raw = 7'h00;
      dp_raw  = 1'b0;
      en_raw  = 2'b00;
      unique case (nxt_state)
         SHOW_LO: begin
            en_raw  = 2'b01;
            seg_raw = glyph_lo;
            dp_raw  = nxt_dp[0];
         end
         SHOW_HI: begin
            if (!(blank_lz && (nxt_val[7:4] == 4'h0) && !nxt_dp[1])) begin
               en_raw  = 2'b10;
               seg_raw = glyph_hi;
               dp_raw  = nxt_dp[1];
            end
         end
         default: begin
            en_raw  = 2'b00;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state    <= BLANK_HI;
         cnt      <= '0;
         pend_val <= '0;
         pend_dp  <= '0;
         disp_val <= '0;
         disp_dp  <= '0;
         seg      <= SEG_DARK;
         dp       <= DP_DARK;
         en       <= EN_DARK;
         frame    <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= last ? '0 : cnt + CW'(1);
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
         end
         if (boundary) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
         end
         seg   <= seg_raw ^ {7{SEG_INV}};
         dp    <= dp_raw ^ SEG_INV;
         en    <= en_raw ^ {2{EN_INV}};
         frame <= boundary;
      end
   end

endmodule

// File: tb/tb_vslc_sevenseg_mux.sv
// Directed bench for vslc_sevenseg_mux with CLK_DIV=4, BLANK_CYCLES=2.
module tb_vslc_sevenseg_mux;

   logic       CLK = 1'b0;
   logic       rst;
   logic [7:0] value;
   logic [1:0] dp_in;
   logic       load;
   logic       blank_lz;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] en;
   logic       frame;

   int checks = 0;
   int errors = 0;

   vslc_sevenseg_mux #(
      .CLK_DIV        (4),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (1),
      .EN_ACTIVE_LOW  (0)
   ) dut (
      .CLK      (CLK),
      .rst      (rst),
      .value    (value),
      .dp_in    (dp_in),
      .load     (load),
      .blank_lz (blank_lz),
      .seg      (seg),
      .dp       (dp),
      .en       (en),
      .frame    (frame)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (frame !== 1'b1 && n < 40);
      chk(tag, {7'd0, frame}, 8'h01);
   endtask

   task automatic chk_out(input string tag, input logic [1:0] e_en,
                          input logic [6:0] e_seg, input logic e_dp);
      chk({tag, ".en"}, {6'd0, en}, {6'd0, e_en});
      chk({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
      chk({tag, ".dp"}, {7'd0, dp}, {7'd0, e_dp});
   endtask

   initial begin
      int last_f;
      int gaps;
      logic [1:0] e_en;
      logic [6:0] e_seg;

      rst = 1'b1;
      value = 8'h00;
      dp_in = 2'b00;
      load = 1'b0;
      blank_lz = 1'b0;

      // reset state
      step();
      step();
      chk_out("rst", 2'b00, 7'h7F, 1'b1);
      chk("rst.frame", {7'd0, frame}, 8'h00);
      rst = 1'b0;
      step();
      chk("rel1.frame", {7'd0, frame}, 8'h00);
      chk("rel1.en", {6'd0, en}, 8'h00);
      step();
      chk("rel2.frame", {7'd0, frame}, 8'h01);
      chk_out("rel2", 2'b01, 7'h40, 1'b1);

      // load 3A and walk one full frame
      value = 8'h3A;
      load = 1'b1;
      step();
      load = 1'b0;
      wait_frame("wf3A");
      for (int i = 0; i < 12; i++) begin
         if (i < 4) begin
            e_en = 2'b01;
            e_seg = 7'h08;
         end else if (i < 6) begin
            e_en = 2'b00;
            e_seg = 7'h7F;
         end else if (i < 10) begin
            e_en = 2'b10;
            e_seg = 7'h30;
         end else begin
            e_en = 2'b00;
            e_seg = 7'h7F;
         end
         chk_out($sformatf("3A.c%0d", i), e_en, e_seg, 1'b1);
         chk($sformatf("3A.f%0d", i), {7'd0, frame}, {7'd0, i == 0});
         step();
      end
      chk("3A.period", {7'd0, frame}, 8'h01);

      // leading zero suppression
      value = 8'h05;
      blank_lz = 1'b1;
      load = 1'b1;
      step();
      load = 1'b0;
      wait_frame("wf05");
      chk_out("05.lo", 2'b01, 7'h12, 1'b1);
      repeat (6) step();
      chk_out("05.lz1", 2'b00, 7'h7F, 1'b1);
      blank_lz = 1'b0;
      step();
      chk_out("05.lz0", 2'b10, 7'h40, 1'b1);
      blank_lz = 1'b1;
      step();
      chk_out("05.lz1b", 2'b00, 7'h7F, 1'b1);
      dp_in = 2'b10;
      load = 1'b1;
      step();
      load = 1'b0;
      dp_in = 2'b00;
      wait_frame("wf05dp");
      chk_out("05dp.lo", 2'b01, 7'h12, 1'b1);
      repeat (6) step();
      chk_out("05dp.hi", 2'b10, 7'h40, 1'b0);

      // last load wins; load on boundary edge is deferred a frame
      value = 8'h11;
      load = 1'b1;
      step();
      value = 8'h22;
      step();
      load = 1'b0;
      wait_frame("wf22");
      chk_out("22.lo", 2'b01, 7'h24, 1'b1);
      repeat (6) step();
      chk_out("22.hi", 2'b10, 7'h24, 1'b1);
      repeat (5) step();
      value = 8'h77;
      load = 1'b1;
      step();
      load = 1'b0;
      chk("bnd.frame", {7'd0, frame}, 8'h01);
      chk_out("bnd.lo", 2'b01, 7'h24, 1'b1);
      repeat (12) step();
      chk("77.frame", {7'd0, frame}, 8'h01);
      chk_out("77.lo", 2'b01, 7'h78, 1'b1);
      repeat (6) step();
      chk_out("77.hi", 2'b10, 7'h78, 1'b1);

      // asynchronous reset mid SHOW_HI
      #2;
      rst = 1'b1;
      #1;
      chk_out("arst", 2'b00, 7'h7F, 1'b1);
      chk("arst.frame", {7'd0, frame}, 8'h00);
      step();
      rst = 1'b0;
      step();
      chk("ar1.frame", {7'd0, frame}, 8'h00);
      step();
      chk("ar2.frame", {7'd0, frame}, 8'h01);
      chk_out("ar2.lo", 2'b01, 7'h40, 1'b1);
      repeat (6) step();
      chk_out("ar2.hi", 2'b00, 7'h7F, 1'b1);

      // free run: frame spacing and enable exclusivity
      last_f = -1;
      gaps = 0;
      for (int t = 1; t <= 126; t++) begin
         step();
         chk("run.en", {7'd0, en == 2'b11}, 8'h00);
         if (frame === 1'b1) begin
            if (last_f >= 0) begin
               chk("run.gap", 8'(t - last_f), 8'd12);
               gaps++;
            end
            last_f = t;
         end
      end
      chk("run.ngaps", 8'(gaps), 8'd10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
